// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, FSM state type and index-width helper for nibble_serial_adder
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-nibble adder still needs a 1-bit index so the counter is never zero-width.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_add.sv
// rtl/nibble_add.sv - combinational 4-bit add-with-carry exposing the carry into bit 3
module nibble_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] low;
  logic [1:0] high;

  // Split at bit 3 so the carry into the sign bit is available for overflow detection.
  assign low  = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, ci};
  assign c3   = low[3];
  assign high = {1'b0, x[3]} + {1'b0, y[3]} + {1'b0, c3};
  assign s    = {high[0], low[2:0]};
  assign co   = high[1];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder computing one nibble per clock behind valid/ready handshakes
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       nib_s;
  logic             nib_co;
  logic             nib_c3;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_q[NIBBLE_W*i +: NIBBLE_W];
        b_nib = b_q[NIBBLE_W*i +: NIBBLE_W];
      end
    end
  end

  nibble_add u_nibble_add (
    .x  (a_nib),
    .y  (b_nib),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co),
    .c3 (nib_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
              sum[NIBBLE_W*i +: NIBBLE_W] <= nib_s;
            end
          end
          carry <= nib_co;
          // The index parks on the last nibble; the next accept clears it.
          if (idx == LAST_IDX) begin
            cout  <= nib_co;
            ovf   <= nib_c3 ^ nib_co;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed vector bench for nibble_serial_adder (WIDTH=16 and WIDTH=4)
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] a = '0, b = '0, sum;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
  logic        in_ready4, out_valid4, cout4, ovf4;
  logic [3:0]  a4 = '0, b4 = '0, sum4;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accepts one operand set, then counts edges until out_valid with a bounded wait.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    int   lat;
    logic ready_seen;
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("in_ready_during_run", 32'(ready_seen), 32'd0);
    check("in_ready_in_done", 32'(in_ready), 32'd0);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    check("out_valid_after_release", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum4", 32'(sum4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      release_result();
    end

    // Backpressure: DONE held while new operands are offered, then out_ready together with in_valid.
    run_op(16'h1234, 16'h1111, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(sum), 32'h2345);
      check("bp_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    end
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("simul_in_ready", 32'(in_ready), 32'd1);
    check("simul_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("simul_accepted", 32'(in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("simul_done", 32'(out_valid), 32'd1);
    check("simul_sum", 32'(sum), 32'h1010);
    release_result();

    // Asynchronous reset after two RUN cycles.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("partial_low_byte", 32'(sum[7:0]), 32'h45);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0F0F, 16'h0101, 1'b0);
    check("post_rst_sum", 32'(sum), 32'h1010);
    check("post_rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    release_result();

    // WIDTH=4 instance: single compute cycle.
    @(negedge clk);
    check("w4_in_ready", 32'(in_ready4), 32'd1);
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("w4_in_ready_run", 32'(in_ready4), 32'd0);
    check("w4_out_valid_run", 32'(out_valid4), 32'd0);
    @(posedge clk); #1;
    check("w4_out_valid", 32'(out_valid4), 32'd1);
    check("w4_sum", 32'(sum4), 32'h2);
    check("w4_cout", 32'(cout4), 32'd1);
    check("w4_ovf", 32'(ovf4), 32'd1);
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("w4_release", 32'(in_ready4), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide adder that adds two WIDTH-bit operands four bits per clock, using a single 4-bit add-with-carry datapath. It sits between operand sources and result consumers. Operands and results pass through valid/ready handshakes. It trades latency (WIDTH/4 cycles) for a one-nibble adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NIBBLES, WIDTH/4, derived; number of compute cycles

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A, unsigned/two's-complement agnostic
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow: carry into bit WIDTH-1 XOR cout

Behaviour:
- Reset (rst_n low, async): state=IDLE, nibble index=0, internal carry=0, operand regs=0, sum=0, cout=0, ovf=0, out_valid=0. Inputs are ignored while rst_n is low.
- in_ready = (state==IDLE), combinational from state only.
- out_valid = (state==DONE), combinational from state only.
- IDLE: on in_valid && in_ready at an edge, latch a, b, cin into operand regs; carry<=cin; idx<=0; go to RUN. With in_valid low, stay in IDLE.
- RUN: each cycle, nibble idx = a[4*idx+:4] + b[4*idx+:4] + carry.
  - Write the result into sum[4*idx+:4]; carry<=nibble carry-out; idx<=idx+1.
  - When idx==NIBBLES-1, also set cout=nibble carry-out and ovf=carry into bit 3 XOR carry-out, then go to DONE.
- DONE: sum, cout and ovf are held stable. On out_ready, go to IDLE. Results stay on the outputs until the next acceptance overwrites them, nibble by nibble.
- Latency: operands accepted at edge E; out_valid is high after edge E+NIBBLES. For WIDTH=4, out_valid is high after edge E+1.
- Throughput: one operation per NIBBLES+2 cycles minimum. Accept and complete never overlap, and in_ready stays 0 throughout RUN and DONE.
- Backpressure: out_ready held low keeps DONE indefinitely. Outputs stay stable and in_valid is ignored.
- out_ready high outside DONE: no effect.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes. New operands are taken from IDLE on a later edge.
- Reset mid-RUN or mid-DONE: the operation is aborted with no partial result signalled, and all outputs return to their reset values.
- idx width: clog2(NIBBLES), minimum 1 bit. idx never exceeds NIBBLES-1.
- Wrap-around: sum is modulo 2^WIDTH. The final carry appears only on cout.

Decomposition:
- Package adder_pkg:
  - NIBBLE_W=4
  - state enum {IDLE, RUN, DONE}, 2 bits
  - function computing the idx width
- Sub-module nibble_add, purely combinational:
  - inputs: x[3:0], y[3:0], ci
  - outputs: s[3:0], co, c3 (carry into bit 3, used for ovf)
- The top level holds the FSM, operand/result registers and idx counter.

Test Plan:
- WIDTH=16: a=0x1234, b=0x1111, cin=0 -> sum=0x2345, cout=0, ovf=0; out_valid rises exactly 4 edges after accept; in_ready=0 during RUN/DONE.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (full carry ripple across all nibbles). Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while pulsing in_valid with new operands -> sum/cout/ovf unchanged, nothing accepted. Raise out_ready -> IDLE next edge, then the next operands are accepted.
- Reset: assert rst_n=0 asynchronously (between clock edges) after 2 RUN cycles of 0x1234+0x1111 -> all outputs 0 immediately, state IDLE. A fresh 0x0F0F+0x0101 then gives 0x1010.
- WIDTH=4 instance: a=0x9, b=0x8, cin=1 -> sum=0x2, cout=1, ovf=1, out_valid one edge after accept.
